// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: press FSM state type
// and the default debounce / long-press constants also used by the light top.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEFAULT = 4;
    localparam int BTN_LONG_DEFAULT     = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-run debouncer. The debounced
// level only changes after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; shorter glitches are discarded.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Plain flop pair for metastability settling; nothing sits between them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button_raw;
            s2 <= s1;
        end
    end

    // Count cycles of disagreement; adopt the new level once the run is long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            held <= 1'b0;
        end else if (s2 == held) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            held <= s2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise and debounce the raw button, then
// classify each press. Short press -> one-cycle `button` pulse; long press
// -> toggle `on_off`. Optional macro BTN_PRESS_COUNT_EN adds an 8-bit
// wrapping count of short presses on port press_count.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = BTN_LONG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_raw,
    output logic       button,
    output logic       on_off,
`ifdef BTN_PRESS_COUNT_EN
    output logic [7:0] press_count,
`endif
    output logic       held
);

    localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [HW-1:0] LIM = HW'(LONG_PRESS_CYCLES - 1);

    btn_state_t    state;
    logic [HW-1:0] hcnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .button_raw (button_raw),
        .held       (held)
    );

    // Press classifier; release is checked before the long threshold so a
    // release on the threshold edge still counts as a short press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hcnt   <= '0;
            button <= 1'b0;
            on_off <= 1'b0;
        end else begin
            button <= 1'b0;
            case (state)
                IDLE: begin
                    if (held) begin
                        state <= PRESSED;
                        hcnt  <= '0;
                    end
                end
                PRESSED: begin
                    if (!held) begin
                        state  <= IDLE;
                        button <= 1'b1;
                    end else if (hcnt + 1'b1 >= LIM) begin
                        state  <= LONG_HELD;
                        hcnt   <= LIM;
                        on_off <= ~on_off;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!held) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTN_PRESS_COUNT_EN
    // Bump the short-press count on the same edge that raises `button`.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         press_count <= '0;
        else if (state == PRESSED && !held) press_count <= press_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised plus directed bench for button_conditioner. The reference model
// works from sampled raw history: held flips once the last DEBOUNCE_CYCLES
// synchronised samples all disagree with it, and each debounced press is
// classified purely by its high duration.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_raw = 1'b0;
    logic button, on_off, held;
`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_raw (button_raw),
        .button     (button),
        .on_off     (on_off),
`ifdef BTN_PRESS_COUNT_EN
        .press_count(press_count),
`endif
        .held       (held)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int q[$];
    bit m_held, m_on, m_btn, m_pend;
    int n, rise, m_cnt;

    function automatic void m_reset();
        q.delete();
        for (int i = 0; i < DEB + 2; i++) q.push_back(0);
        m_held = 0; m_on = 0; m_btn = 0; m_pend = 0; m_cnt = 0; rise = 0;
    endfunction

    // One rising edge of the model. q holds the last DEB+2 raw samples;
    // the synchronised value seen at this edge is two samples old, so the
    // debounce window is q[0..DEB-1].
    function automatic void m_edge();
        bit all_diff;
        n++;
        if (rst) begin
            m_reset();
            return;
        end
        q.push_back(int'(button_raw));
        void'(q.pop_front());
        m_btn  = m_pend;
        m_pend = 0;
        if (m_btn) m_cnt = (m_cnt + 1) % 256;
        if (m_held && (n - rise) == LONG) m_on = !m_on;
        all_diff = 1;
        for (int i = 0; i < DEB; i++) if (q[i] == int'(m_held)) all_diff = 0;
        if (all_diff) begin
            m_held = !m_held;
            if (m_held) rise = n;
            else if ((n - rise) < LONG) m_pend = 1;
        end
    endfunction

    task automatic step(input bit v);
        button_raw = v;
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("held", 32'(held), 32'(m_held));
        chk("button", 32'(button), 32'(m_btn));
        chk("on_off", 32'(on_off), 32'(m_on));
`ifdef BTN_PRESS_COUNT_EN
        chk("press_count", 32'(press_count), 32'(m_cnt));
`endif
    endtask

    task automatic run(input bit v, input int len);
        for (int i = 0; i < len; i++) step(v);
    endtask

    // Assert reset between edges and confirm the outputs drop without a clock.
    task automatic async_rst();
        @(posedge clk);
        m_edge();
        #2 rst = 1'b1;
        #1;
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_button", 32'(button), 32'd0);
        chk("rst_on_off", 32'(on_off), 32'd0);
        m_reset();
        @(posedge clk); m_edge();
        @(posedge clk); m_edge();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n = 0;
        m_reset();
        // reset with button already high
        rst = 1'b1;
        run(1'b1, 2);
        rst = 1'b0;
        run(1'b1, 10);
        run(1'b0, 12);
        // glitch shorter than the debounce window
        run(1'b1, 3);
        run(1'b0, 10);
        // bounce then short press
        run(1'b1, 1); run(1'b0, 1); run(1'b1, 11);
        run(1'b0, 12);
        // two long presses: on, then off
        run(1'b1, 30); run(1'b0, 12);
        run(1'b1, 30); run(1'b0, 12);
        // threshold boundary: one cycle short of long, then exactly long
        run(1'b1, LONG - 1); run(1'b0, 12);
        run(1'b1, LONG);     run(1'b0, 12);
        // reset mid-press while on_off is high, then fresh long press
        run(1'b1, 12);
        async_rst();
        run(1'b1, 30); run(1'b0, 12);
        // randomised segments with occasional bounce bursts
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < int'($urandom_range(1, 4)); b++) step(1'($urandom));
            end
            run(1'b1, int'($urandom_range(1, 24)));
            run(1'b0, int'($urandom_range(1, 14)));
        end
        run(1'b0, 12);
`ifdef BTN_PRESS_COUNT_EN
        // wrap the short-press counter
        for (int p = 0; p < 256; p++) begin
            run(1'b1, 6);
            run(1'b0, 6);
        end
        run(1'b0, 4);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that feeds the dynamic LED light block.
- Takes the raw, bouncy push-button input and synchronises and debounces it.
- Classifies each press as short or long.
- A short press produces a one-cycle `button` pulse, which drives the light block's colour-step input.
- A long press toggles the `on_off` level, which drives the light block's enable.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes. Legal range 2..65535.
- LONG_PRESS_CYCLES, 16: debounced-high cycles after which a press counts as long. Must be greater than 1.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- button_raw  input  1  raw push-button level, asynchronous to clk.
- button  output  1  one-cycle pulse on completion of a short press.
- on_off  output  1  level that toggles once per long press.
- held  output  1  debounced button level, for status and debug.

Behaviour:
- Reset: the asynchronous rst clears every flop.
  - button=0, on_off=0, held=0.
  - Synchroniser=0, debounce counter=0, hold counter=0, FSM=IDLE.
- Synchroniser: two flops, s1<=button_raw, s2<=s1. No logic is allowed between them.
- Debounce:
  - If s2==held, the debounce counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s2!=held, held<=s2 and the counter clears.
  - Net latency: held follows a clean raw edge DEBOUNCE_CYCLES+2 edges after the first clock edge that samples the new raw value.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation is ignored.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES)+1.
- Hold counter width: $clog2(LONG_PRESS_CYCLES)+1. It saturates and never wraps.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE: held==1 moves to PRESSED and clears the hold counter.
  - PRESSED, held==0: move to IDLE and assert button=1 for exactly the next cycle.
  - PRESSED, held==1: the hold counter increments. On reaching LONG_PRESS_CYCLES-1, move to LONG_HELD and toggle on_off (on_off<=~on_off) in the same edge.
  - LONG_HELD: stay while held==1. held==0 moves to IDLE with no pulse.
- Output rules:
  - button is registered and is never high for two consecutive cycles.
  - Each press yields exactly one of: a button pulse, or an on_off toggle. Never both, never neither, provided the press passes debounce.
  - on_off changes only on the LONG_HELD entry edge.
- Release on the threshold edge: if held falls in the same cycle the hold counter would hit the threshold, release wins. The FSM moves to IDLE, button pulses, and on_off is unchanged.
- Reset mid-press: all outputs drop immediately, including on_off returning to 0. If button_raw is still high after rst deasserts, it is debounced afresh and treated as a new press.
- No combinational path exists from any input to any output.

Optional Feature:
- BTN_PRESS_COUNT_EN defined:
  - Adds output port press_count, 8 bits, reset 0.
  - press_count increments on the same edge that asserts button, i.e. short presses only.
  - Wraps 255->0.
  - Long presses do not change it.
- BTN_PRESS_COUNT_EN undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package btn_pkg holds:
  - The FSM state typedef (IDLE, PRESSED, LONG_HELD), 2-bit encoding.
  - Default constants BTN_DEBOUNCE_DEFAULT=4 and BTN_LONG_DEFAULT=16, which the light-level top also uses.
- One sub-module, btn_debounce: synchroniser plus debounce counter, outputting `held`.
- The FSM and press counter stay in button_conditioner.

Test Plan:
All scenarios use default parameters and a 10 ns clock.
- Reset: rst=1 for 2 cycles with button_raw=1 -> button=0, on_off=0, held=0 throughout. After release, held rises 6 edges later.
- Glitch: button_raw high for 3 cycles then low -> held stays 0, no button pulse, on_off=0.
- Bounce plus short press:
  - Stimulus: raw toggles 1/0/1 at 1-cycle spacing, then stays high 10 cycles, then low.
  - Response: exactly one button pulse, one cycle wide, after held falls; on_off stays 0.
- Long press:
  - Raw high for 30 cycles -> on_off goes 0->1 exactly once, 16 edges after held rises.
  - Release gives no button pulse.
  - Repeat the press -> on_off returns to 0.
- Reset mid-press: raw high, rst pulsed at cycle 12 -> outputs clear asynchronously. Raw is held afterwards -> a fresh long press toggles on_off to 1.
- BTN_PRESS_COUNT_EN defined: 3 short presses plus 1 long press -> press_count=3. Then 256 further short presses -> press_count=3 (wrap verified).
